// File: rtl/hc595_rx.sv
// Receive side of a 74HC595 shift/latch link: oversamples shcp/stcp/DS/OE and rebuilds sel/seg.
// Optional partial-frame timeout is enabled with `define HC595_RX_TIMEOUT_EN.
module hc595_rx #(
    parameter int DATA_W      = 14,
    parameter int SEL_W       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shcp,
    input  logic               stcp,
    input  logic               DS,
    input  logic               OE,
    output logic [SEL_W-1:0]   sel,
    output logic [7:0]         seg,
    output logic               frame_valid,
    output logic               frame_err,
    output logic               blank
);
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_OVER} state_t;

    logic [SYNC_STAGES-1:0] r_shcp_sync, r_stcp_sync, r_ds_sync, r_oe_sync;
    logic                   r_shcp_d, r_stcp_d, r_blank;
    state_t                 r_state, w_state_next;
    logic [CNT_W-1:0]       r_count, w_count_next;
    logic [DATA_W-1:0]      r_shreg, w_shreg_next;
    logic [SEL_W-1:0]       r_sel;
    logic [7:0]             r_seg;
    logic                   r_frame_valid, r_frame_err;
    logic                   w_shcp_rise, w_stcp_rise, w_ds, w_load, w_err_set, w_timeout;

    // All four pins share one chain depth so DS stays aligned with its shcp edge.
    assign w_ds        = r_ds_sync[SYNC_STAGES-1];
    assign w_shcp_rise = r_shcp_sync[SYNC_STAGES-1] & ~r_shcp_d;
    assign w_stcp_rise = r_stcp_sync[SYNC_STAGES-1] & ~r_stcp_d;

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_shreg_next = r_shreg;
        w_load       = 1'b0;
        w_err_set    = 1'b0;
        if (w_shcp_rise) begin
            w_shreg_next = {r_shreg[DATA_W-2:0], w_ds};
            w_count_next = (r_count == CNT_W'(DATA_W + 1)) ? r_count : r_count + 1'b1;
            w_state_next = (r_count >= CNT_W'(DATA_W)) ? ST_OVER : ST_SHIFT;
        end else if (w_timeout && !w_stcp_rise) begin
            w_state_next = ST_IDLE;
            w_count_next = '0;
            w_err_set    = 1'b1;
        end
        // Latch sees the post-shift count so tied shcp/stcp behave like a real 595.
        if (w_stcp_rise) begin
            if (w_count_next == CNT_W'(DATA_W)) begin
                w_load = 1'b1;
            end else begin
                w_err_set = 1'b1;
            end
            w_state_next = ST_IDLE;
            w_count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shcp_sync   <= '0;
            r_stcp_sync   <= '0;
            r_ds_sync     <= '0;
            r_oe_sync     <= '1;
            r_shcp_d      <= 1'b0;
            r_stcp_d      <= 1'b0;
            r_blank       <= 1'b1;
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_shreg       <= '0;
            r_sel         <= '0;
            r_seg         <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_shcp_sync   <= {r_shcp_sync[SYNC_STAGES-2:0], shcp};
            r_stcp_sync   <= {r_stcp_sync[SYNC_STAGES-2:0], stcp};
            r_ds_sync     <= {r_ds_sync[SYNC_STAGES-2:0], DS};
            r_oe_sync     <= {r_oe_sync[SYNC_STAGES-2:0], OE};
            r_shcp_d      <= r_shcp_sync[SYNC_STAGES-1];
            r_stcp_d      <= r_stcp_sync[SYNC_STAGES-1];
            r_blank       <= r_oe_sync[SYNC_STAGES-1];
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_shreg       <= w_shreg_next;
            r_frame_valid <= w_load;
            if (w_load) begin
                r_seg       <= w_shreg_next[DATA_W-1:SEL_W];
                r_sel       <= w_shreg_next[SEL_W-1:0];
                r_frame_err <= 1'b0;
            end else if (w_err_set) begin
                r_frame_err <= 1'b1;
            end
        end
    end

`ifdef HC595_RX_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0] r_timer;

    assign w_timeout = (r_state != ST_IDLE) && (r_timer == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_shcp_rise || w_state_next == ST_IDLE) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign sel         = r_sel;
    assign seg         = r_seg;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign blank       = r_blank;
endmodule

// File: doc/hc595_rx.md
Name: hc595_rx

Overview:
- Receive-side counterpart of the 74HC595 shift/latch link (stcp/shcp/DS/OE).
- Deserialises a frame driven by the display controller and reconstructs the 6-bit digit select and 8-bit segment word.
- Used for loopback verification of the display path on-chip and for driving a second board's display from a forwarded 595 bus.
- All pins are asynchronous to clk; the block oversamples them.

Parameters:
- DATA_W, 14, bits per frame; must equal SEL_W + 8.
- SEL_W, 6, width of the sel field.
- SYNC_STAGES, 2, synchroniser depth applied to every input pin (minimum 2).
- TIMEOUT_CYC, 1024, idle clk cycles before a partial frame is discarded; used only with HC595_RX_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- shcp  input  1  shift clock; data is sampled on its rising edge
- stcp  input  1  storage/latch clock; its rising edge commits the frame
- DS  input  1  serial data
- OE  input  1  output enable, active-low
- sel  output  SEL_W  latched digit select
- seg  output  8  latched segment pattern
- frame_valid  output  1  one-cycle pulse when sel/seg update
- frame_err  output  1  sticky flag: last latch carried the wrong bit count
- blank  output  1  synchronised OE (1 = display blanked)

Behaviour:
- Reset, clk edge with rst=1:
  - sel=0, seg=0, frame_valid=0, frame_err=0, blank=1.
  - Shift register=0, bit count=0.
  - Sync chains: shcp=0, stcp=0, DS=0, OE=1.
  - Reset mid-frame discards all partial bits.
- Synchronisation:
  - shcp, stcp, DS and OE each pass through SYNC_STAGES flops of identical depth, preserving DS-to-shcp alignment.
  - A rising edge is detected by comparing the synced value with a one-cycle-delayed copy.
- Input timing: shcp and stcp high and low times ≥ SYNC_STAGES+1 clk periods. DS stable from SYNC_STAGES+1 cycles before to 1 cycle after the shcp rise.
- Shift, on shcp rise:
  - shreg <= {shreg[DATA_W-2:0], DS_sync}.
  - Count increments, saturating at DATA_W+1 (overflow marker).
  - The first bit sent ends up as the MSB.
- Field mapping at latch: seg = shreg[DATA_W-1:SEL_W], sel = shreg[SEL_W-1:0]. seg[7] is transmitted first, sel[0] last.
- State machine:
  - IDLE (count=0): shcp rise -> SHIFT.
  - SHIFT (1..DATA_W): shcp rise increments the count; a rise at count=DATA_W -> OVER.
  - OVER: further shcp rises stay in OVER.
  - stcp rise in any state -> IDLE, count cleared.
- On stcp rise:
  - Count == DATA_W: sel/seg load from shreg, frame_valid=1 for exactly one cycle, frame_err cleared.
  - Count != DATA_W (including 0 and OVER): sel/seg hold, frame_valid stays 0, frame_err set.
- Simultaneous shcp and stcp rise in the same cycle: shift first, then the latch evaluates the post-shift count and data (matches 595 behaviour when both pins are tied).
- Latency: pin edge first captured at clk edge N; the resulting register update (shift, sel/seg, frame_valid, blank) occurs at edge N+SYNC_STAGES.
- blank tracks the synced OE continuously and is independent of frame state.
- Register map size: ≤ 2*SYNC_STAGES*4 sync flops + DATA_W shift + 5-bit count.

Optional Feature:
- Macro: HC595_RX_TIMEOUT_EN.
- Defined:
  - A counter runs while the state is SHIFT or OVER and resets on each shcp rise.
  - On reaching TIMEOUT_CYC cycles: state -> IDLE, count=0, frame_err set, sel/seg untouched.
  - The next shcp rise starts a fresh frame.
  - A timeout and an shcp rise in the same cycle: the shift wins, and the timer restarts.
- Undefined: no timer logic; a partial frame waits indefinitely for stcp.

Test Plan:
- Reset then idle 50 cycles -> sel=0, seg=0, blank=1, frame_valid never asserted.
- Send 14 bits for seg=8'hC0, sel=6'b111110 MSB-first, then stcp -> frame_valid one cycle at N+2, seg=8'hC0, sel=6'h3E, frame_err=0.
- Send 13 bits then stcp -> frame_err=1, sel/seg keep previous values. A following correct 14-bit frame clears frame_err and updates outputs.
- Send 16 bits then stcp -> frame_err=1, no update. Also: stcp with zero bits shifted -> frame_err=1.
- 14th shcp rise coincident with stcp rise -> frame accepted, the 14th bit lands in sel[0]. Assert rst after 7 bits, then send a full frame -> only the new frame is latched.
- HC595_RX_TIMEOUT_EN, TIMEOUT_CYC=64: send 5 bits, wait 64 cycles, send 14 bits plus stcp -> frame_err set after the timeout. The new frame is accepted cleanly and clears frame_err. OE toggling 0/1 -> blank follows with 2-cycle delay.
